// File: rtl/pwm_multi.sv
// N-channel PWM: one shared prescaler and period counter, per-channel double-buffered duty
// and live output polarity. Edge-aligned or center-aligned counting is selected per period.
module pwm_multi #(
    parameter int R  = 8,
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   dvsr,
    input  logic          mode,
    input  logic [N-1:0]  polarity,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [R:0]    wr_duty,
    output logic [N-1:0]  pwm_out,
    output logic          period_tick
);

    localparam logic [R-1:0] D_MAX = '1;

    logic [31:0]  q_reg;
    logic [R-1:0] d_reg;
    logic         dir_reg;        // 0 = counting up, 1 = counting down
    logic         mode_act_reg;
    logic         tick;
    logic         boundary;
    logic [N-1:0] raw;

    // >= rather than == so a dvsr lowered below q wraps immediately
    assign tick = (q_reg >= dvsr);

    assign boundary = tick && (mode_act_reg ? ((d_reg == '0) && dir_reg)
                                            : (d_reg == D_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg        <= '0;
            d_reg        <= '0;
            dir_reg      <= 1'b0;
            mode_act_reg <= 1'b0;
            period_tick  <= 1'b0;
        end else begin
            q_reg       <= tick ? '0 : q_reg + 32'd1;
            period_tick <= boundary;
            // Every period starts at d=0 counting up, whichever mode is latched next.
            if (boundary) begin
                d_reg        <= '0;
                dir_reg      <= 1'b0;
                mode_act_reg <= mode;
            end else if (tick) begin
                if (!mode_act_reg) begin
                    d_reg   <= d_reg + 1'b1;
                    dir_reg <= 1'b0;
                end else if (!dir_reg) begin
                    if (d_reg == D_MAX)
                        dir_reg <= 1'b1;
                    else
                        d_reg <= d_reg + 1'b1;
                end else begin
                    d_reg <= d_reg - 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic [R:0] shadow_reg;
            logic [R:0] duty_act_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg   <= '0;
                    duty_act_reg <= '0;
                end else begin
                    if (wr_en && (wr_ch == CW'(gi)))
                        shadow_reg <= wr_duty;
                    // Old shadow moves to active even if a write lands this same cycle.
                    if (boundary)
                        duty_act_reg <= shadow_reg;
                end
            end

            assign raw[gi] = ({1'b0, d_reg} < duty_act_reg);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm_out <= '0;
        else
            pwm_out <= raw ^ polarity;
    end

endmodule
